// File: rtl/ej32_st_ser.sv
// ---------------------------------------------------------------------------
// ej32_st_ser -- store serializer
//
// Takes one byte/short/word store request and writes it to a byte-wide
// memory bus one byte per accepted cycle, most significant byte first
// (big-endian), at consecutive byte addresses.
//
// Parameters
//   DSZ      store data width in bits (>= 32)
//   ASZ      memory byte-address width in bits
//
// Ports
//   clk      clock, all state updates on the rising edge
//   rst      asynchronous active-low reset
//   st_req   store request, taken only when the serializer is ready
//   st_len   00 byte, 01 short, 10/11 word
//   st_addr  byte address of the first (most significant) byte
//   st_data  store value, low 8/16/32 bits used according to st_len
//   mem_rdy  memory takes the presented byte this cycle
//   mem_we   byte write strobe
//   mem_a    byte write address
//   mem_d    byte write data
//   busy     store in progress
//   done     one-cycle pulse after the last byte was taken
// ---------------------------------------------------------------------------
module ej32_st_ser #(
    parameter int DSZ = 32,
    parameter int ASZ = 17
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           st_req,
    input  logic [1:0]     st_len,
    input  logic [ASZ-1:0] st_addr,
    input  logic [DSZ-1:0] st_data,
    input  logic           mem_rdy,
    output logic           mem_we,
    output logic [ASZ-1:0] mem_a,
    output logic [7:0]     mem_d,
    output logic           busy,
    output logic           done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;

    logic [ASZ-1:0] addr_q;     // address of the byte currently presented
    logic [7:0]     byte_q;     // byte currently presented
    logic [DSZ-1:0] rest_q;     // bytes still to send, left-aligned
    logic [2:0]     cnt_q;      // bytes remaining including the presented one

    logic           ready;
    logic           accept;
    logic           byte_ack;
    logic           last_byte;
    logic [2:0]     n_bytes;
    logic [DSZ-1:0] aligned;

    // -----------------------------------------------------------------------
    // Request decode
    // -----------------------------------------------------------------------
    assign ready     = (state_q == S_IDLE) || (state_q == S_DONE);
    assign accept    = ready && st_req;
    assign byte_ack  = (state_q == S_SEND) && mem_rdy;
    assign last_byte = (cnt_q == 3'd1);

    always_comb begin
        n_bytes = 3'd4;
        unique case (st_len)
            2'b00:   n_bytes = 3'd1;
            2'b01:   n_bytes = 3'd2;
            default: n_bytes = 3'd4;
        endcase
    end

    // Left-align the selected bytes so the first byte to send sits in the
    // top byte lane. Shifting left also pushes the unused upper bytes out,
    // so they can never reach the bus.
    always_comb begin
        aligned = st_data << (DSZ - 32);
        unique case (st_len)
            2'b00:   aligned = st_data << (DSZ - 8);
            2'b01:   aligned = st_data << (DSZ - 16);
            default: aligned = st_data << (DSZ - 32);
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next state and state-decoded outputs
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        mem_we  = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                state_d = st_req ? S_SEND : S_IDLE;
            end
            S_SEND: begin
                mem_we = 1'b1;
                busy   = 1'b1;
                // A stall (mem_rdy=0) simply keeps us here with all
                // presented values held; there is no timeout.
                if (mem_rdy && last_byte) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done = 1'b1;
                // Ready again: a request here starts the next store right
                // away, giving back-to-back stores with a single gap cycle.
                state_d = st_req ? S_SEND : S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Datapath: capture on accept, advance on each taken byte.
    // Requests arriving while busy fall through both branches untouched.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q <= '0;
            byte_q <= '0;
            rest_q <= '0;
            cnt_q  <= '0;
        end else if (accept) begin
            addr_q <= st_addr;
            byte_q <= aligned[DSZ-1 -: 8];
            rest_q <= {aligned[DSZ-9:0], 8'h00};
            cnt_q  <= n_bytes;
        end else if (byte_ack) begin
            // Address wraps naturally at 2^ASZ.
            addr_q <= addr_q + 1'b1;
            byte_q <= rest_q[DSZ-1 -: 8];
            rest_q <= {rest_q[DSZ-9:0], 8'h00};
            cnt_q  <= cnt_q - 3'd1;
        end
    end

    // Bus address/data come straight from flops; outside SEND they simply
    // keep their last value.
    assign mem_a = addr_q;
    assign mem_d = byte_q;

endmodule

// File: tb/tb_ej32_st_ser.sv
// ---------------------------------------------------------------------------
// tb_ej32_st_ser -- directed, scoreboard-based bench for ej32_st_ser.
// Each store pushes its expected (address, byte) sequence; a negedge monitor
// compares every presented byte against the queue head and pops on accept.
// ---------------------------------------------------------------------------
module tb_ej32_st_ser;

    localparam int DSZ = 32;
    localparam int ASZ = 17;

    typedef struct {
        logic [ASZ-1:0] a;
        logic [7:0]     d;
    } wr_t;

    logic           clk;
    logic           rst;
    logic           st_req;
    logic [1:0]     st_len;
    logic [ASZ-1:0] st_addr;
    logic [DSZ-1:0] st_data;
    logic           mem_rdy;
    logic           mem_we;
    logic [ASZ-1:0] mem_a;
    logic [7:0]     mem_d;
    logic           busy;
    logic           done;

    wr_t sb[$];
    int  pass_cnt = 0;
    int  fail_cnt = 0;
    int  tot_cnt  = 0;

    ej32_st_ser #(.DSZ(DSZ), .ASZ(ASZ)) dut (
        .clk     (clk),
        .rst     (rst),
        .st_req  (st_req),
        .st_len  (st_len),
        .st_addr (st_addr),
        .st_data (st_data),
        .mem_rdy (mem_rdy),
        .mem_we  (mem_we),
        .mem_a   (mem_a),
        .mem_d   (mem_d),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tot_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor: every cycle mem_we is up, the presented byte must match the
    // queue head (this also covers hold during stalls); pop when taken.
    always @(negedge clk) begin
        if (rst && mem_we) begin
            if (sb.size() == 0) begin
                check("unexpected_write", {7'd0, mem_a, mem_d}, 32'hFFFF_FFFF);
            end else begin
                check("wr_addr", 32'(mem_a), 32'(sb[0].a));
                check("wr_data", 32'(mem_d), 32'(sb[0].d));
                if (mem_rdy) void'(sb.pop_front());
            end
        end
    end

    // Drive one store; stall_idx/stall_n hold byte stall_idx off for stall_n
    // cycles (a junk request is pulsed during the stall). Returns in the
    // DONE cycle, sampled 1 time unit after the edge.
    task automatic do_store(input logic [1:0] len, input logic [ASZ-1:0] addr,
                            input logic [31:0] data, input int stall_idx,
                            input int stall_n, input int exp_cycles);
        int n, k, bi, pres;
        wr_t w;
        n = (len == 2'b00) ? 1 : (len == 2'b01) ? 2 : 4;
        for (int i = 0; i < n; i++) begin
            w.a = addr + ASZ'(i);
            w.d = 8'(data >> (8 * (n - 1 - i)));
            sb.push_back(w);
        end
        st_req  = 1'b1;
        st_len  = len;
        st_addr = addr;
        st_data = data;
        mem_rdy = 1'b1;
        @(posedge clk); #1;
        st_req = 1'b0;
        check("busy_after_accept", 32'(busy), 32'd1);
        check("we_after_accept", 32'(mem_we), 32'd1);
        k = 0; bi = 0; pres = 0;
        while (!done && k < 64) begin
            mem_rdy = !(bi == stall_idx && pres < stall_n);
            if (bi == stall_idx && pres == 1) begin
                st_req  = 1'b1;
                st_len  = 2'b00;
                st_addr = 17'h0ABCD;
                st_data = 32'hEEEE_EEEE;
            end
            @(posedge clk); #1;
            st_req = 1'b0;
            k++;
            if (mem_rdy) begin
                bi++;
                pres = 0;
            end else begin
                pres++;
            end
        end
        mem_rdy = 1'b1;
        check("send_cycles", 32'(k), 32'(exp_cycles));
        check("done_pulse", 32'(done), 32'd1);
        check("busy_in_done", 32'(busy), 32'd0);
        check("we_in_done", 32'(mem_we), 32'd0);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            check("idle_done", 32'(done), 32'd0);
            check("idle_we", 32'(mem_we), 32'd0);
        end
    endtask

    initial begin
        st_req  = 1'b0;
        st_len  = 2'b00;
        st_addr = '0;
        st_data = '0;
        mem_rdy = 1'b1;
        rst     = 1'b1;
        #2 rst  = 1'b0;
        #5;
        check("rst_we", 32'(mem_we), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_addr", 32'(mem_a), 32'd0);
        check("rst_data", 32'(mem_d), 32'd0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;

        // Word store, first request after reset release
        do_store(2'b10, 17'h00100, 32'h1234_5678, -1, 0, 4);
        idle_cycles(2);

        // Byte and short stores; upper bytes must never show up
        do_store(2'b00, 17'h00010, 32'hAABB_CCDD, -1, 0, 1);
        idle_cycles(1);
        do_store(2'b01, 17'h00020, 32'hAABB_CCDD, -1, 0, 2);
        idle_cycles(1);
        // st_len=11 behaves as a word
        do_store(2'b11, 17'h00040, 32'hDEAD_BEEF, -1, 0, 4);
        idle_cycles(1);

        // Stall 3 cycles on byte 2, junk request mid-store is ignored
        do_store(2'b10, 17'h00100, 32'h1234_5678, 1, 3, 7);
        idle_cycles(2);

        // Address wrap, then back-to-back store issued in the DONE cycle
        do_store(2'b10, 17'h1FFFE, 32'h1122_3344, -1, 0, 4);
        do_store(2'b00, 17'h00005, 32'h0000_0099, -1, 0, 1);
        idle_cycles(1);

        // Reset in the middle of a word store, after the 2nd byte is taken
        sb.push_back('{a: 17'h00200, d: 8'hCA});
        sb.push_back('{a: 17'h00201, d: 8'hFE});
        sb.push_back('{a: 17'h00202, d: 8'hF0});
        sb.push_back('{a: 17'h00203, d: 8'h0D});
        st_req  = 1'b1;
        st_len  = 2'b10;
        st_addr = 17'h00200;
        st_data = 32'hCAFE_F00D;
        mem_rdy = 1'b1;
        @(posedge clk); #1;
        st_req = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("pre_rst_we", 32'(mem_we), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("async_rst_we", 32'(mem_we), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_done", 32'(done), 32'd0);
        check("async_rst_addr", 32'(mem_a), 32'd0);
        check("aborted_bytes_left", 32'(sb.size()), 32'd2);
        sb.delete();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("rst_hold_done", 32'(done), 32'd0);
            check("rst_hold_we", 32'(mem_we), 32'd0);
        end
        #2 rst = 1'b1;
        do_store(2'b10, 17'h00300, 32'hA1B2_C3D4, -1, 0, 4);
        idle_cycles(2);

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule

// File: doc/ej32_st_ser.md
EJ32_ST_SER -- requirements
Module: ej32_st_ser

Interface
REQ-001 Parameter DSZ, default 32, store data width in bits.
REQ-002 Parameter ASZ, default 17, memory byte-address width in bits.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 st_req  input  1  store request; accepted only when ready.
REQ-006 st_len  input  2  store width: 00 byte, 01 short (2 bytes), 10 word (4 bytes), 11 treated as word.
REQ-007 st_addr  input  ASZ  byte address of the first (most significant) stored byte.
REQ-008 st_data  input  DSZ  value to store; the low 8/16/32 bits are used per st_len.
REQ-009 mem_rdy  input  1  memory accepts the byte presented this cycle when mem_we=1.
REQ-010 mem_we  output  1  byte write strobe to memory bus.
REQ-011 mem_a  output  ASZ  byte write address.
REQ-012 mem_d  output  8  byte write data.
REQ-013 busy  output  1  high while a store is in progress (SEND state).
REQ-014 done  output  1  one-cycle pulse after the last byte of a store is accepted.

Function
REQ-015 FSM states: IDLE, SEND, DONE; ready = (state==IDLE or state==DONE).
REQ-016 IDLE/DONE with st_req=1: capture st_data, st_addr, and byte count n (1/2/4) into registers; next state SEND.
REQ-017 IDLE/DONE with st_req=0: next state IDLE.
REQ-018 st_req while busy=1 is ignored; no queuing, no effect on the store in progress.
REQ-019 Byte order big-endian: first byte is data[8n-1:8n-8], last byte is data[7:0]; word order is [31:24],[23:16],[15:8],[7:0].
REQ-020 SEND: mem_we=1, mem_a=current address, mem_d=current byte; all three are driven from registers (no combinational path from st_* to mem_*).
REQ-021 SEND with mem_rdy=0: hold mem_a, mem_d, remaining count; mem_we stays 1 (stall, unbounded).
REQ-022 SEND with mem_rdy=1: address +1, shift to the next byte, remaining count -1; when the last byte is accepted, next state DONE.
REQ-023 Address increment wraps modulo 2^ASZ (all-ones +1 -> 0); no error flagged.
REQ-024 DONE: done=1, busy=0, mem_we=0 for exactly one cycle; a new st_req in DONE is accepted (back-to-back stores with one gap cycle).
REQ-025 Minimum latency: req cycle -> first mem_we next cycle; n bytes with mem_rdy always 1 take n SEND cycles; done asserts in cycle n+1 after acceptance.
REQ-026 mem_we=0 in IDLE and DONE; mem_a/mem_d hold their last values when mem_we=0 (don't-care for memory).
REQ-027 Bytes above the selected width in st_data are never written.

Reset
REQ-028 rst=0 forces, asynchronously: state IDLE, mem_we=0, busy=0, done=0, mem_a=0, mem_d=0, count=0, data register 0.
REQ-029 Reset asserted during SEND aborts the store immediately; no further bytes are written and no done pulse occurs.
REQ-030 First st_req is accepted on the first rising edge with rst=1.

Verification
REQ-031 Word store: st_len=10, st_addr=0x00100, st_data=0x12345678, mem_rdy=1 -> writes 0x12@0x00100, 0x34@0x00101, 0x56@0x00102, 0x78@0x00103 in 4 consecutive cycles, then done pulse of 1 cycle.
REQ-032 Byte/short: st_len=00, data=0xAABBCCDD, addr=0x10 -> single write 0xDD@0x10; st_len=01, same data, addr=0x20 -> 0xCC@0x20, 0xDD@0x21; bytes 0xAA/0xBB never appear.
REQ-033 Stall: word store with mem_rdy=0 for 3 cycles on byte 2 -> mem_a/mem_d held at 0x00101/0x34 for 4 cycles, total 7 SEND cycles, order unchanged; st_req pulsed mid-store is ignored.
REQ-034 Wrap and back-to-back: word store at addr 0x1FFFE, then st_req in the DONE cycle with st_len=00, addr=0x5, data=0x99 -> writes to 0x1FFFE, 0x1FFFF, 0x00000, 0x00001, one idle cycle, then 0x99@0x5.
REQ-035 Reset mid-op: rst=0 asserted asynchronously after 2nd byte of a word store -> mem_we falls without waiting for a clock edge, no done pulse; after release, a new store executes normally.
